// File: rtl/alu_ctrl.sv
// Sequencing controller for a MIPS-style ALU datapath: selects the result source for
// single-cycle funct codes and steps a multi-cycle DIVU through load, iterate and Hi/Lo writeback.
module alu_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  input  logic [5:0] Signal,
  output logic       op_ready,
  output logic [1:0] out_sel,
  output logic       out_valid,
  output logic       div_start,
  output logic       div_step,
  output logic [5:0] step_cnt,
  output logic       hilo_we,
  output logic       illegal,
  output logic [1:0] fsm_state
);

  // Handshake: an operation transfers on a rising edge where op_valid && op_ready;
  // op_ready is high only in IDLE, and op_valid is ignored (never queued) otherwise.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_LOAD = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_WB   = 2'd3
  } state_t;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

  state_t state;
  logic   accept;

  assign accept    = op_valid && op_ready;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_ready  <= 1'b0;
      out_sel   <= 2'b00;
      out_valid <= 1'b0;
      div_start <= 1'b0;
      div_step  <= 1'b0;
      step_cnt  <= 6'd0;
      hilo_we   <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      div_start <= 1'b0;
      hilo_we   <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        IDLE: begin
          op_ready <= 1'b1;
          if (accept) begin
            case (Signal)
              F_AND, F_OR, F_ADD, F_SUB, F_SLT: begin
                out_sel   <= 2'b00;
                out_valid <= 1'b1;
              end
              F_SLL: begin
                out_sel   <= 2'b01;
                out_valid <= 1'b1;
              end
              F_MFHI: begin
                out_sel   <= 2'b10;
                out_valid <= 1'b1;
              end
              F_MFLO: begin
                out_sel   <= 2'b11;
                out_valid <= 1'b1;
              end
              F_DIVU: begin
                state     <= DIV_LOAD;
                div_start <= 1'b1;
                op_ready  <= 1'b0;
              end
              default: illegal <= 1'b1;
            endcase
          end
        end
        DIV_LOAD: begin
          state    <= DIV_RUN;
          div_step <= 1'b1;
          step_cnt <= 6'd0;
        end
        DIV_RUN: begin
          if (step_cnt == LAST_STEP) begin
            state    <= DIV_WB;
            div_step <= 1'b0;
            step_cnt <= 6'd0;
            hilo_we  <= 1'b1;
          end else begin
            step_cnt <= step_cnt + 6'd1;
          end
        end
        DIV_WB: begin
          // Ready rises together with the return to IDLE so a waiting MFHI/MFLO sees written Hi/Lo.
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: a table of single-cycle operations applied back to back,
// then hand-written DIVU, blocked-MFLO and reset-during-divide sequences.
module tb_alu_ctrl;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic [5:0] Signal;
  logic       op_ready;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       div_start;
  logic       div_step;
  logic [5:0] step_cnt;
  logic       hilo_we;
  logic       illegal;
  logic [1:0] fsm_state;

  int n_vec;
  int n_bad;

  alu_ctrl #(.DIV_CYCLES(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .Signal    (Signal),
    .op_ready  (op_ready),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .div_start (div_start),
    .div_step  (div_step),
    .step_cnt  (step_cnt),
    .hilo_we   (hilo_we),
    .illegal   (illegal),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sig;
    logic [1:0] exp_sel;
    logic       exp_valid;
    logic       exp_illegal;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    Signal   = 6'b000000;

    vecs[0]  = '{6'b100000, 2'b00, 1'b1, 1'b0}; // ADD
    vecs[1]  = '{6'b100100, 2'b00, 1'b1, 1'b0}; // AND
    vecs[2]  = '{6'b000000, 2'b01, 1'b1, 1'b0}; // SLL
    vecs[3]  = '{6'b010000, 2'b10, 1'b1, 1'b0}; // MFHI
    vecs[4]  = '{6'b100101, 2'b00, 1'b1, 1'b0}; // OR
    vecs[5]  = '{6'b111111, 2'b00, 1'b0, 1'b1}; // illegal, sel held
    vecs[6]  = '{6'b010010, 2'b11, 1'b1, 1'b0}; // MFLO
    vecs[7]  = '{6'b000001, 2'b11, 1'b0, 1'b1}; // illegal, sel held
    vecs[8]  = '{6'b100010, 2'b00, 1'b1, 1'b0}; // SUB
    vecs[9]  = '{6'b101010, 2'b00, 1'b1, 1'b0}; // SLT
    vecs[10] = '{6'b000000, 2'b01, 1'b1, 1'b0}; // SLL
    vecs[11] = '{6'b010000, 2'b10, 1'b1, 1'b0}; // MFHI

    #2;
    check("rst_op_ready", 8'(op_ready), 8'd0);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_sel", 8'(out_sel), 8'd0);
    check("rst_state", 8'(fsm_state), 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 8'(op_ready), 8'd1);

    // Back-to-back single-cycle operations, one accepted per edge.
    op_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      Signal = vecs[i].sig;
      step();
      check($sformatf("v%0d_out_sel", i), 8'(out_sel), 8'(vecs[i].exp_sel));
      check($sformatf("v%0d_out_valid", i), 8'(out_valid), 8'(vecs[i].exp_valid));
      check($sformatf("v%0d_illegal", i), 8'(illegal), 8'(vecs[i].exp_illegal));
      check($sformatf("v%0d_op_ready", i), 8'(op_ready), 8'd1);
    end
    op_valid = 1'b0;
    step();
    check("idle_out_valid", 8'(out_valid), 8'd0);
    check("idle_sel_held", 8'(out_sel), 8'b10);
    check("idle_illegal", 8'(illegal), 8'd0);

    // DIVU with an MFLO held valid behind it: must wait until ready returns.
    op_valid = 1'b1;
    Signal   = 6'b011011;
    step();
    Signal = 6'b010010;
    check("divu_start", 8'(div_start), 8'd1);
    check("divu_load_state", 8'(fsm_state), 8'd1);
    check("divu_load_ready", 8'(op_ready), 8'd0);
    check("divu_load_valid", 8'(out_valid), 8'd0);
    for (int k = 0; k < 32; k++) begin
      step();
      check($sformatf("run%0d_step", k), 8'(div_step), 8'd1);
      check($sformatf("run%0d_cnt", k), 8'(step_cnt), 8'(k));
      check($sformatf("run%0d_ready", k), 8'(op_ready), 8'd0);
      check($sformatf("run%0d_valid_we", k), 8'({out_valid, hilo_we, div_start}), 8'd0);
    end
    step();
    check("wb_hilo_we", 8'(hilo_we), 8'd1);
    check("wb_step", 8'(div_step), 8'd0);
    check("wb_cnt", 8'(step_cnt), 8'd0);
    check("wb_ready", 8'(op_ready), 8'd0);
    step();
    check("post_div_ready", 8'(op_ready), 8'd1);
    check("post_div_we", 8'(hilo_we), 8'd0);
    check("post_div_valid", 8'(out_valid), 8'd0);
    step();
    check("mflo_valid", 8'(out_valid), 8'd1);
    check("mflo_sel", 8'(out_sel), 8'b11);
    op_valid = 1'b0;
    step();

    // Reset asserted mid-divide at step_cnt 15.
    op_valid = 1'b1;
    Signal   = 6'b011011;
    step();
    op_valid = 1'b0;
    repeat (16) step();
    check("pre_rst_cnt", 8'(step_cnt), 8'd15);
    rst_n = 1'b0;
    #1;
    check("async_rst_outs",
          8'({op_ready, out_valid, div_start, div_step, hilo_we, illegal}), 8'd0);
    check("async_rst_cnt", 8'(step_cnt), 8'd0);
    check("async_rst_sel", 8'(out_sel), 8'd0);
    check("async_rst_state", 8'(fsm_state), 8'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst2_ready", 8'(op_ready), 8'd1);
    for (int k = 0; k < 40; k++) begin
      step();
      check($sformatf("abandon%0d", k), 8'({hilo_we, div_step, fsm_state}), 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
